// File: rtl/chunk_sequencer.sv
// chunk_sequencer
//   Control FSM driving the compute cluster in chunk-padded mode. Preloads the
//   first IFM chunk and filter set, then runs chunks back to back while the
//   next IFM chunk (and, at set boundaries, the next filter set) is prefetched
//   into the idle bank of the double-buffered memories.
// Ports
//   clk_i, rst_i              clock, synchronous active-low reset
//   cfg_start_i               start pulse, sampled only while idle
//   cfg_ifm_per_flt_i         IFM chunks per filter set (N)
//   cfg_flt_num_i             filter sets to process (F)
//   cfg_rd_last_i             last sparsemap index, latched at start
//   ifm_load_req_o/_done_i    IFM loader handshake (level request, done pulse)
//   flt_load_req_o/_done_i    filter loader handshake (level request, done pulse)
//   ifm_wr/rd_sel_o           IFM bank selects
//   filter_wr/rd_sel_o        filter bank selects
//   run_valid_o               cluster run enable
//   total_chunk_start_o       one-cycle chunk start
//   total_chunk_end_i         chunk finished, honoured only while running
//   acc_buf_sel_o/out_buf_sel_o  accumulation/output buffer select
//   rd_sparsemap_last_o       latched cfg_rd_last_i
//   busy_o, done_o            activity flag, one-cycle completion pulse
module chunk_sequencer #(
  parameter int OUTPUT_BUF_NUM   = 4,
  parameter int RD_SPARSEMAP_NUM = 8,
  parameter int CNT_W            = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                cfg_start_i,
  input  logic [$clog2(OUTPUT_BUF_NUM):0]     cfg_ifm_per_flt_i,
  input  logic [CNT_W-1:0]                    cfg_flt_num_i,
  input  logic [$clog2(RD_SPARSEMAP_NUM)-1:0] cfg_rd_last_i,
  output logic                                ifm_load_req_o,
  input  logic                                ifm_load_done_i,
  output logic                                flt_load_req_o,
  input  logic                                flt_load_done_i,
  output logic                                ifm_wr_sel_o,
  output logic                                ifm_rd_sel_o,
  output logic                                filter_wr_sel_o,
  output logic                                filter_rd_sel_o,
  output logic                                run_valid_o,
  output logic                                total_chunk_start_o,
  input  logic                                total_chunk_end_i,
  output logic [$clog2(OUTPUT_BUF_NUM)-1:0]   acc_buf_sel_o,
  output logic [$clog2(OUTPUT_BUF_NUM)-1:0]   out_buf_sel_o,
  output logic [$clog2(RD_SPARSEMAP_NUM)-1:0] rd_sparsemap_last_o,
  output logic                                busy_o,
  output logic                                done_o
);

  localparam int NW = $clog2(OUTPUT_BUF_NUM) + 1;
  localparam int BW = $clog2(OUTPUT_BUF_NUM);
  localparam int RW = $clog2(RD_SPARSEMAP_NUM);
  localparam logic [NW-1:0] N_MAX = NW'(OUTPUT_BUF_NUM);

  typedef enum logic [2:0] {
    S_IDLE, S_PRELOAD, S_START, S_RUN, S_WAIT_LOAD, S_DONE
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [NW-1:0]   r_n, r_c, w_n_cfg;
  logic [CNT_W-1:0] r_f, r_fi, w_f_cfg;
  logic [RW-1:0]   r_rd_last;
  logic            r_ifm_req, r_flt_req, r_ifm_rdy, r_flt_rdy;
  logic            r_ifm_wr, r_ifm_rd, r_flt_wr, r_flt_rd;
  logic            w_wrap, w_last, w_ifm_ok, w_flt_ok, w_need_ok;
  logic            w_preload_go, w_advance;

  // Clamp the chunk count into 1..OUTPUT_BUF_NUM and the set count to >= 1.
  always_comb begin
    w_n_cfg = cfg_ifm_per_flt_i;
    if (cfg_ifm_per_flt_i == '0)
      w_n_cfg = NW'(1);
    else if (cfg_ifm_per_flt_i > N_MAX)
      w_n_cfg = N_MAX;
    w_f_cfg = (cfg_flt_num_i == '0) ? CNT_W'(1) : cfg_flt_num_i;
  end

  assign w_wrap = (r_c == r_n - NW'(1));
  assign w_last = w_wrap && (r_fi == r_f - CNT_W'(1));
  // A done pulse arriving on the checking edge counts as ready.
  assign w_ifm_ok  = r_ifm_rdy || (r_ifm_req && ifm_load_done_i);
  assign w_flt_ok  = r_flt_rdy || (r_flt_req && flt_load_done_i);
  assign w_need_ok = w_ifm_ok && (!w_wrap || w_flt_ok);

  always_comb begin
    w_state_nxt         = r_state;
    w_preload_go        = 1'b0;
    w_advance           = 1'b0;
    run_valid_o         = 1'b0;
    total_chunk_start_o = 1'b0;
    done_o              = 1'b0;
    busy_o              = (r_state != S_IDLE);
    unique case (r_state)
      S_IDLE:
        if (cfg_start_i) w_state_nxt = S_PRELOAD;
      // Preload only looks at the registered flags, so the cluster starts
      // two cycles after the last preload done.
      S_PRELOAD:
        if (r_ifm_rdy && r_flt_rdy) begin
          w_state_nxt  = S_START;
          w_preload_go = 1'b1;
        end
      S_START: begin
        run_valid_o         = 1'b1;
        total_chunk_start_o = 1'b1;
        w_state_nxt         = S_RUN;
      end
      S_RUN: begin
        run_valid_o = 1'b1;
        if (total_chunk_end_i) begin
          if (w_last) begin
            w_state_nxt = S_DONE;
          end else if (w_need_ok) begin
            w_state_nxt = S_START;
            w_advance   = 1'b1;
          end else begin
            w_state_nxt = S_WAIT_LOAD;
          end
        end
      end
      S_WAIT_LOAD:
        if (w_need_ok) begin
          w_state_nxt = S_START;
          w_advance   = 1'b1;
        end
      S_DONE: begin
        done_o      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Later assignments deliberately override the generic done-pulse handling
  // (e.g. a same-edge done whose flag is consumed immediately).
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state   <= S_IDLE;
      r_n       <= '0;
      r_c       <= '0;
      r_f       <= '0;
      r_fi      <= '0;
      r_rd_last <= '0;
      r_ifm_req <= 1'b0;
      r_flt_req <= 1'b0;
      r_ifm_rdy <= 1'b0;
      r_flt_rdy <= 1'b0;
      r_ifm_wr  <= 1'b0;
      r_ifm_rd  <= 1'b0;
      r_flt_wr  <= 1'b0;
      r_flt_rd  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_ifm_req && ifm_load_done_i) begin
        r_ifm_req <= 1'b0;
        r_ifm_rdy <= 1'b1;
      end
      if (r_flt_req && flt_load_done_i) begin
        r_flt_req <= 1'b0;
        r_flt_rdy <= 1'b1;
      end
      if (r_state == S_IDLE && cfg_start_i) begin
        r_n       <= w_n_cfg;
        r_f       <= w_f_cfg;
        r_rd_last <= cfg_rd_last_i;
        r_c       <= '0;
        r_fi      <= '0;
        r_ifm_wr  <= 1'b0;
        r_flt_wr  <= 1'b0;
        r_ifm_req <= 1'b1;
        r_flt_req <= 1'b1;
        r_ifm_rdy <= 1'b0;
        r_flt_rdy <= 1'b0;
      end
      if (w_preload_go) begin
        r_ifm_rd  <= 1'b0;
        r_ifm_wr  <= 1'b1;
        r_flt_rd  <= 1'b0;
        r_flt_wr  <= 1'b1;
        r_ifm_rdy <= 1'b0;
        r_flt_rdy <= 1'b0;
      end
      if (r_state == S_START) begin
        if (!w_last) r_ifm_req <= 1'b1;
        if (r_c == '0 && r_fi != r_f - CNT_W'(1)) r_flt_req <= 1'b1;
      end
      if (w_advance) begin
        r_ifm_rd  <= ~r_ifm_rd;
        r_ifm_wr  <= ~r_ifm_wr;
        r_ifm_rdy <= 1'b0;
        if (w_wrap) begin
          r_flt_rd  <= ~r_flt_rd;
          r_flt_wr  <= ~r_flt_wr;
          r_flt_rdy <= 1'b0;
          r_c       <= '0;
          r_fi      <= r_fi + CNT_W'(1);
        end else begin
          r_c <= r_c + NW'(1);
        end
      end
    end
  end

  // The buffer select steps exactly like the chunk index within a set.
  assign acc_buf_sel_o       = r_c[BW-1:0];
  assign out_buf_sel_o       = r_c[BW-1:0];
  assign ifm_load_req_o      = r_ifm_req;
  assign flt_load_req_o      = r_flt_req;
  assign ifm_wr_sel_o        = r_ifm_wr;
  assign ifm_rd_sel_o        = r_ifm_rd;
  assign filter_wr_sel_o     = r_flt_wr;
  assign filter_rd_sel_o     = r_flt_rd;
  assign rd_sparsemap_last_o = r_rd_last;

endmodule

// File: doc/chunk_sequencer.md
Name: chunk_sequencer

Overview:
- Control FSM that drives the Compute_Cluster in chunk-padded mode.
- Preloads the first IFM chunk and filter set into the double-buffered memories.
- Runs each chunk and prefetches the next IFM chunk and filter set into the idle bank while the current chunk runs.
- Steps acc/out buffer selects and toggles read/write bank selects at chunk boundaries. Replaces the hand-coded sequencing in the thin-CNN bench.

Parameters:
- OUTPUT_BUF_NUM, 4, accumulation/output buffers per compute unit; max IFM chunks per filter set.
- RD_SPARSEMAP_NUM, 8, sparsemap words per memory; sets the width of rd_sparsemap_last_o.
- CNT_W, 16, width of the filter-set counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-low
- cfg_start_i  in  1  start pulse; sampled only in IDLE
- cfg_ifm_per_flt_i  in  $clog2(OUTPUT_BUF_NUM)+1  IFM chunks per filter set (N), 1..OUTPUT_BUF_NUM
- cfg_flt_num_i  in  CNT_W  filter sets to process (F)
- cfg_rd_last_i  in  $clog2(RD_SPARSEMAP_NUM)  last sparsemap index for a chunk
- ifm_load_req_o  out  1  request loader to write one IFM chunk into bank ifm_wr_sel_o
- ifm_load_done_i  in  1  one-cycle pulse, IFM load complete
- flt_load_req_o  out  1  request loader to write all filters into bank filter_wr_sel_o
- flt_load_done_i  in  1  one-cycle pulse, filter load complete
- ifm_wr_sel_o, ifm_rd_sel_o  out  1  IFM bank selects
- filter_wr_sel_o, filter_rd_sel_o  out  1  filter bank selects
- run_valid_o  out  1  cluster run enable
- total_chunk_start_o  out  1  one-cycle chunk start
- total_chunk_end_i  in  1  chunk finished, from cluster
- acc_buf_sel_o, out_buf_sel_o  out  $clog2(OUTPUT_BUF_NUM)  buffer selects, always equal
- rd_sparsemap_last_o  out  $clog2(RD_SPARSEMAP_NUM)  latched cfg_rd_last_i
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst_i=0 at a clock edge):
  - State IDLE.
  - All outputs 0.
  - Counters and pending flags cleared.
  - Applies mid-operation too: requests drop next cycle; no done_o is produced.
- States: IDLE, PRELOAD, START, RUN, WAIT_LOAD, DONE.
- IDLE:
  - On cfg_start_i, latch N, F and rd_last. N=0 is treated as 1; N>OUTPUT_BUF_NUM is clamped; F=0 is treated as 1.
  - Set ifm_wr_sel=filter_wr_sel=0 and assert both load requests. Go to PRELOAD.
- Load requests are levels:
  - Each stays high until its done pulse is sampled, then drops the next cycle and sets a ready flag.
  - A done pulse while the request is low is ignored.
  - A done pulse on the same edge as the ready check counts as ready.
- PRELOAD: when both ready, toggle all four bank selects (rd=0, wr=1), clear the ready flags, go to START.
- START (exactly one cycle):
  - run_valid_o=1, total_chunk_start_o=1.
  - Issue prefetches for the current chunk index c (0..N-1) of filter set f (0..F-1):
    - IFM: request if the current chunk is not the global last (f,c)≠(F-1,N-1).
    - Filter: request if c==0 and f<F-1; request only once per set.
  - Go to RUN.
- RUN:
  - run_valid_o=1. total_chunk_end_i outside RUN is ignored.
  - On total_chunk_end_i at the global last chunk: go to DONE.
  - Otherwise the next chunk is c+1, or c=0, f+1 on wrap. Needed loads: IFM always; filter when wrapping to a new set.
  - If all needed ready flags are set (including a same-cycle done): go to START. Otherwise go to WAIT_LOAD.
- WAIT_LOAD: run_valid_o=0; go to START once all needed ready flags are set.
- Every transition into START from RUN or WAIT_LOAD:
  - Toggle IFM rd/wr sels.
  - Toggle filter rd/wr sels only on a set wrap.
  - Advance acc/out_buf_sel: increment, resetting to 0 at N-1.
  - Consume the used ready flags.
- DONE: done_o=1 for one cycle, run_valid_o=0, go to IDLE. Bank selects hold their values.
- Latency:
  - cfg_start_i to first request: 1 cycle.
  - Last load done to total_chunk_start_o: 2 cycles from PRELOAD.
  - total_chunk_end_i to next start: 1 cycle if data is prefetched.
- cfg_start_i while busy is ignored. Config inputs are not resampled mid-run.

Test Plan:
- N=2, F=2, both loads done 3 cycles after request, end 20 cycles after each start → 4 start pulses; out_buf_sel 0,1,0,1; filter_rd_sel toggles once (before start 3); 3 IFM and 1 filter prefetch; done_o after 4th end.
- N=1, F=1 → no prefetch requests; one start; done_o 1 cycle after end; busy_o low next.
- IFM done arrives 10 cycles after chunk end → WAIT_LOAD with run_valid_o=0 for 10 cycles; start 1 cycle after done.
- ifm_load_done_i on the same edge as total_chunk_end_i → no WAIT_LOAD; start next cycle.
- rst_i low mid-RUN for 1 cycle → all outputs 0 next cycle, no done_o; cfg_start_i afterwards restarts cleanly with selects 0.
- cfg_start_i pulsed in RUN, and a spurious total_chunk_end_i in PRELOAD → both ignored; chunk counts unchanged.
